// File: rtl/prog_run_pkg.sv
// Shared types for the program load/run controller: FSM states and result codes.
package prog_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    STAT_NONE     = 3'd0,
    STAT_OK       = 3'd1,
    STAT_TIMEOUT  = 3'd2,
    STAT_ABORT    = 3'd3,
    STAT_OVERFLOW = 3'd4,
    STAT_EMPTY    = 3'd5
  } status_e;

endpackage

// File: rtl/run_watchdog.sv
// Saturating run-cycle counter with a watchdog limit compare (limit 0 never expires).
module run_watchdog #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          count_en,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          expired
);

  // Count run cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  // The limit-th run cycle is the one where the count still reads limit-1.
  always_comb begin
    expired = (limit != '0) && (count == (limit - CW'(1)));
  end

endmodule

// File: rtl/prog_run_ctrl.sv
// Streams a program into the core instruction memory, then starts the core and
// supervises the run with a watchdog, reporting a result code.
module prog_run_ctrl
  import prog_run_pkg::*;
#(
  parameter int IW    = 9,
  parameter int DEPTH = 256,
  parameter int CW    = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          run_req,
  input  logic          abort,
  input  logic [CW-1:0] timeout_cycles,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          core_start,
  input  logic          core_done,
  output logic          busy,
  output logic [2:0]    status,
  output logic [CW-1:0] cycle_count,
  output logic [AW:0]   prog_len
);

  localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

  state_e      state_q, state_d;
  status_e     status_q, status_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] base_len;
  logic        accept;
  logic        overflow;
  logic        wd_clear;
  logic        wd_en;
  logic        wd_expired;

  run_watchdog #(.CW(CW)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wd_clear),
    .count_en (wd_en),
    .limit    (timeout_cycles),
    .count    (cycle_count),
    .expired  (wd_expired)
  );

  // Load-port handshake and memory write strobe; a word taken in IDLE starts a new program at 0.
  always_comb begin
    ld_ready   = rst_n && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    accept     = ld_valid && ld_ready;
    base_len   = (state_q == ST_IDLE) ? '0 : len_q;
    overflow   = accept && (base_len == LEN_FULL);
    imem_we    = accept && !overflow;
    imem_addr  = base_len[AW-1:0];
    imem_wdata = ld_data;
    busy       = (state_q != ST_IDLE);
    status     = status_q;
    prog_len   = len_q;
  end

  // Next-state, result code, program length and core control; abort has top priority.
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    len_d      = len_q;
    core_start = 1'b0;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          status_d = STAT_NONE;
          wd_clear = 1'b1;
          len_d    = LEN_ONE;
          state_d  = ld_last ? ST_IDLE : ST_LOAD;
        end else if (run_req) begin
          if (len_q != '0) begin
            status_d = STAT_NONE;
            state_d  = ST_ARM;
          end else begin
            status_d = STAT_EMPTY;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          status_d = STAT_ABORT;
          len_d    = '0;
          state_d  = ST_IDLE;
        end else if (overflow) begin
          status_d = STAT_OVERFLOW;
          len_d    = '0;
          state_d  = ST_IDLE;
        end else if (accept) begin
          len_d = len_q + LEN_ONE;
          if (ld_last) begin
            status_d = STAT_NONE;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_ARM: begin
        core_start = 1'b1;
        wd_clear   = 1'b1;
        if (abort) begin
          status_d = STAT_ABORT;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wd_en = 1'b1;
        if (abort) begin
          status_d = STAT_ABORT;
          state_d  = ST_IDLE;
        end else if (core_done) begin
          status_d = STAT_OK;
          state_d  = ST_DONE;
        end else if (wd_expired) begin
          status_d = STAT_TIMEOUT;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state, result code and program length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      status_q <= STAT_NONE;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed self-checking bench for prog_run_ctrl (default depth plus a DEPTH=8 instance).
module tb_prog_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [8:0]  ld_data;
  logic        ld_last;
  logic        run_req;
  logic        abort;
  logic [15:0] timeout_cycles;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_wdata;
  logic        core_start;
  logic        core_done;
  logic        busy;
  logic [2:0]  status;
  logic [15:0] cycle_count;
  logic [8:0]  prog_len;

  logic        ld_valid8;
  logic        ld_ready8;
  logic [8:0]  ld_data8;
  logic        imem_we8;
  logic [2:0]  imem_addr8;
  logic [8:0]  imem_wdata8;
  logic        core_start8;
  logic        busy8;
  logic [2:0]  status8;
  logic [15:0] cycle_count8;
  logic [3:0]  prog_len8;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_count8 = 0;
  int start_count = 0;
  int snap;

  logic [8:0] mem [256];
  logic [8:0] prog_a [10];
  logic [8:0] prog_b [3];

  prog_run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .run_req(run_req), .abort(abort),
    .timeout_cycles(timeout_cycles), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_start(core_start), .core_done(core_done),
    .busy(busy), .status(status), .cycle_count(cycle_count), .prog_len(prog_len)
  );

  prog_run_ctrl #(.DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid8), .ld_ready(ld_ready8),
    .ld_data(ld_data8), .ld_last(1'b0), .run_req(1'b0), .abort(1'b0),
    .timeout_cycles(16'd0), .imem_we(imem_we8), .imem_addr(imem_addr8),
    .imem_wdata(imem_wdata8), .core_start(core_start8), .core_done(1'b0),
    .busy(busy8), .status(status8), .cycle_count(cycle_count8), .prog_len(prog_len8)
  );

  always #5 clk = ~clk;

  // Instruction memory model plus write and start-pulse counters.
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      wr_count <= wr_count + 1;
    end
    if (imem_we8) wr_count8 <= wr_count8 + 1;
    if (core_start) start_count <= start_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // One cycle: drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic valid, input logic [8:0] data, input logic last,
                               input logic run, input logic abrt, input logic done);
    @(negedge clk);
    ld_valid  = valid;
    ld_data   = data;
    ld_last   = last;
    run_req   = run;
    abort     = abrt;
    core_done = done;
    #1;
  endtask

  initial begin
    prog_a = '{9'b010000101, 9'b010010001, 9'b011000011, 9'b000111100, 9'b101010101,
               9'b110000001, 9'b001100110, 9'b111111000, 9'b000000111, 9'b100100100};
    prog_b = '{9'b101100011, 9'b000011110, 9'b111000101};
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_data = '0; ld_last = 1'b0; run_req = 1'b0;
    abort = 1'b0; core_done = 1'b0; timeout_cycles = '0;
    ld_valid8 = 1'b0; ld_data8 = '0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_ld_ready", 32'(ld_ready), 0);
    checkOutput("rst_imem_we", 32'(imem_we), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_status", 32'(status), 0);
    checkOutput("rst_cycle_count", 32'(cycle_count), 0);
    checkOutput("rst_prog_len", 32'(prog_len), 0);
    checkOutput("rst_core_start", 32'(core_start), 0);
    ld_valid = 1'b0;
    #20;
    @(negedge clk) rst_n = 1'b1;

    // Run with nothing loaded
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("empty_status", 32'(status), 5);
    checkOutput("empty_busy", 32'(busy), 0);
    checkOutput("empty_no_start", 32'(start_count), 0);

    // Load ten words
    snap = wr_count;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, prog_a[i], (i == 9), 0, 0, 0);
      checkOutput("load_we", 32'(imem_we), 1);
      checkOutput("load_addr", 32'(imem_addr), i);
      checkOutput("load_ready", 32'(ld_ready), 1);
      if (i == 1) checkOutput("load_busy", 32'(busy), 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("load_prog_len", 32'(prog_len), 10);
    checkOutput("load_idle", 32'(busy), 0);
    checkOutput("load_status", 32'(status), 0);
    checkOutput("load_writes", 32'(wr_count - snap), 10);
    for (int i = 0; i < 10; i++) checkOutput("load_mem", 32'(mem[i]), 32'(prog_a[i]));

    // Run, core_done in the seventh run cycle
    snap = start_count;
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("arm_start", 32'(core_start), 1);
    checkOutput("arm_ready", 32'(ld_ready), 0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (k == 1) checkOutput("run_start_low", 32'(core_start), 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ok_status", 32'(status), 1);
    checkOutput("ok_cycles", 32'(cycle_count), 7);
    checkOutput("ok_done_busy", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ok_idle", 32'(busy), 0);
    checkOutput("ok_one_start", 32'(start_count - snap), 1);
    checkOutput("ok_prog_len", 32'(prog_len), 10);

    // Re-run without reload, watchdog at 20 cycles
    timeout_cycles = 16'd20;
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("to_start", 32'(core_start), 1);
    for (int k = 1; k <= 20; k++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("to_not_yet", 32'(status), 0);
    checkOutput("to_busy_run", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("to_status", 32'(status), 2);
    checkOutput("to_cycles", 32'(cycle_count), 20);
    checkOutput("to_done_busy", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("to_idle", 32'(busy), 0);
    timeout_cycles = '0;

    // Abort together with core_done, third run cycle
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("abort_status", 32'(status), 3);
    checkOutput("abort_idle", 32'(busy), 0);

    // Abort in IDLE does nothing
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_abort_busy", 32'(busy), 0);
    checkOutput("idle_abort_len", 32'(prog_len), 10);

    // Abort mid-load: the accepted word is still written, program discarded
    applyStimulus(1, 9'h0AA, 0, 0, 0, 0);
    checkOutput("ab_load_addr0", 32'(imem_addr), 0);
    applyStimulus(1, 9'h155, 0, 0, 1, 0);
    checkOutput("ab_load_we", 32'(imem_we), 1);
    checkOutput("ab_load_addr1", 32'(imem_addr), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ab_load_status", 32'(status), 3);
    checkOutput("ab_load_len", 32'(prog_len), 0);
    checkOutput("ab_load_mem", 32'(mem[1]), 32'h155);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ab_load_empty", 32'(status), 5);

    // Overflow on the DEPTH=8 instance
    snap = wr_count8;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ld_valid8 = 1'b1;
      ld_data8 = 9'(i + 1);
      #1;
      checkOutput("ovf_we", 32'(imem_we8), (i < 8) ? 1 : 0);
      if (i < 8) checkOutput("ovf_addr", 32'(imem_addr8), i);
    end
    @(negedge clk);
    ld_valid8 = 1'b0;
    #1;
    checkOutput("ovf_status", 32'(status8), 4);
    checkOutput("ovf_len", 32'(prog_len8), 0);
    checkOutput("ovf_writes", 32'(wr_count8 - snap), 8);
    checkOutput("ovf_idle", 32'(busy8), 0);

    // Reset in the middle of a run
    for (int i = 0; i < 3; i++) applyStimulus(1, prog_a[i], (i == 2), 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mid_arm_start", 32'(core_start), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_start", 32'(core_start), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_status", 32'(status), 0);
    checkOutput("mid_rst_cycles", 32'(cycle_count), 0);
    checkOutput("mid_rst_len", 32'(prog_len), 0);
    checkOutput("mid_rst_ready", 32'(ld_ready), 0);
    @(negedge clk) rst_n = 1'b1;

    // Reload and run to completion
    for (int i = 0; i < 3; i++) applyStimulus(1, prog_b[i], (i == 2), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("reload_len", 32'(prog_len), 3);
    for (int i = 0; i < 3; i++) checkOutput("reload_mem", 32'(mem[i]), 32'(prog_b[i]));
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rerun_status", 32'(status), 1);
    checkOutput("rerun_cycles", 32'(cycle_count), 2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rerun_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
